// File: rtl/bcd_decade_extender.sv
// Purpose: resync a rippling BCD ones digit, filter glitches, extend into tens/hundreds (000-999) and audit the counter.
// Latency: cnt_in stable before edge E updates ones/tens/hundreds at edge E+FILT+1; wrap is high for the following cycle.
// Backpressure: none; the upstream counter must hold each value for FILT+2 cycles or steps are lost and flagged.
module bcd_decade_extender #(
  parameter int FILT = 2
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic [3:0] cnt_in,
  input  logic       clr,
  output logic [3:0] ones,
  output logic [3:0] tens,
  output logic [3:0] hundreds,
  output logic       valid,
  output logic       wrap,
  output logic       ovf,
  output logic       seq_err,
  output logic       bad_code
);

  localparam logic [2:0] FILT_C = 3'(FILT);
  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] TRACK  = 1'b1;

  logic [0:0] state;
  logic [3:0] s1, s2, cand;
  logic [2:0] stab;
  logic [1:0] fill;
  logic       reach, accept, legal, in_seq, is_wrap;
  logic [3:0] ones_inc;

  assign valid = (state == TRACK);

  // Acceptance decode: the value in s2 becomes cand this edge, so judge s2 itself.
  always_comb begin
    reach    = 1'b0;
    if (fill[1]) begin
      if (s2 != cand) reach = (FILT_C == 3'd1);
      else            reach = (stab == FILT_C - 3'd1);
    end
    accept   = reach && ((s2 != ones) || (state == IDLE));
    legal    = (s2 <= 4'd9);
    ones_inc = (ones == 4'd9) ? 4'd0 : ones + 4'd1;
    in_seq   = (s2 == ones_inc);
    is_wrap  = (ones == 4'd9) && (s2 == 4'd0);
  end

  // Two-flop synchronizer plus stability filter; reset contents of s1/s2 are not samples, so
  // the filter waits until the chain has refilled with real data before counting.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      s1   <= 4'd0;
      s2   <= 4'd0;
      fill <= 2'b00;
      cand <= 4'd0;
      stab <= 3'd0;
    end else begin
      s1   <= cnt_in;
      s2   <= s1;
      fill <= {fill[0], 1'b1};
      if (fill[1]) begin
        if (s2 != cand) begin
          cand <= s2;
          stab <= 3'd1;
        end else if (stab != FILT_C) begin
          stab <= stab + 3'd1;
        end
      end
    end
  end

  // Ones digit, IDLE/TRACK state and the wrap pulse; clr never blocks these.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      ones  <= 4'd0;
      state <= IDLE;
      wrap  <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (accept && legal) begin
        ones <= s2;
        if (state == IDLE) state <= TRACK;
        else if (is_wrap)  wrap  <= 1'b1;
      end
    end
  end

  // Tens/hundreds chain and sticky flags; clr takes priority over increment and flag setting.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      tens     <= 4'd0;
      hundreds <= 4'd0;
      ovf      <= 1'b0;
      seq_err  <= 1'b0;
      bad_code <= 1'b0;
    end else if (clr) begin
      tens     <= 4'd0;
      hundreds <= 4'd0;
      ovf      <= 1'b0;
      seq_err  <= 1'b0;
      bad_code <= 1'b0;
    end else if (accept) begin
      if (!legal) begin
        bad_code <= 1'b1;
      end else if (state == TRACK) begin
        if (!in_seq) begin
          seq_err <= 1'b1;
        end else if (is_wrap) begin
          if (tens != 4'd9) begin
            tens <= tens + 4'd1;
          end else begin
            tens <= 4'd0;
            if (hundreds != 4'd9) begin
              hundreds <= hundreds + 4'd1;
            end else begin
              hundreds <= 4'd0;
              ovf      <= 1'b1;
            end
          end
        end
      end
    end
  end

endmodule
